btn_debounce_multi: RTL and testbench

//  Parametrised N-channel debouncer for push-buttons/switches; successor to single-button debouncer.
//  Per channel: 2-FF synchroniser, configurable stable-time filter, clean level, press/release pulses.

---
 rtl/btn_debounce_pkg.sv | 19 +
 rtl/btn_debounce_multi_if.sv | 29 ++
 rtl/btn_debounce_chan.sv | 78 +++++++
 rtl/btn_debounce_multi.sv | 42 ++++
 tb/tb_btn_debounce_multi.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared types and width helpers for the multi-channel button debouncer.
// Long-press support is enabled with BTN_DEBOUNCE_LONG_PRESS_EN.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    PLS_PRESS,
    PLS_REL,
    PLS_LONG
  } pls_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DEBOUNCE = 1000000;
  localparam int DEF_LONG = 100000000;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_multi_if.sv
// Button bank bundle: raw pins in, clean level and event pulses out.
// Master drives the pins, slave is the debouncer.
interface btn_debounce_multi_if #(
  parameter int NUM_CH = 4
);

  logic [NUM_CH-1:0] btn_raw;
  logic [NUM_CH-1:0] btn_level;
  logic [NUM_CH-1:0] press_pls;
  logic [NUM_CH-1:0] rel_pls;
  logic [NUM_CH-1:0] long_pls;

  modport master (
    output btn_raw,
    input  btn_level,
    input  press_pls,
    input  rel_pls,
    input  long_pls
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output press_pls,
    output rel_pls,
    output long_pls
  );

endinterface

// File: rtl/btn_debounce_chan.sv
// One debounce channel: 2-FF sync, stable-time filter, edge pulses.
// Hold counter and long_pls exist only with BTN_DEBOUNCE_LONG_PRESS_EN.
module btn_debounce_chan
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int LONG_CYCLES     = DEF_LONG,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_pls,
  output logic rel_pls,
  output logic long_pls
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          s;

  assign s = sync[1] ^ POL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= '0;
      cnt       <= '0;
      level     <= 1'b0;
      press_pls <= 1'b0;
      rel_pls   <= 1'b0;
    end else begin
      sync      <= {sync[0], raw};
      press_pls <= 1'b0;
      rel_pls   <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level     <= s;
        cnt       <= '0;
        press_pls <= s;
        rel_pls   <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam int HW = cnt_width(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold;

  // Saturating so the pulse fires once per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold     <= '0;
      long_pls <= 1'b0;
    end else begin
      long_pls <= level && (hold == HOLD_LAST);
      if (!level) begin
        hold <= '0;
      end else if (hold != HOLD_MAX) begin
        hold <= hold + 1'b1;
      end
    end
  end
`else
  assign long_pls = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel push-button debouncer, one channel instance per pin.
// Optional long-press pulse via BTN_DEBOUNCE_LONG_PRESS_EN.
module btn_debounce_multi
  import btn_debounce_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int LONG_CYCLES     = DEF_LONG,
  parameter int ACTIVE_LOW      = 0
) (
  input logic clk,
  input logic rst_n,
  btn_debounce_multi_if.slave bus
);

  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] press;
  logic [NUM_CH-1:0] rel;
  logic [NUM_CH-1:0] lng;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (bus.btn_raw[i]),
      .level    (level[i]),
      .press_pls(press[i]),
      .rel_pls  (rel[i]),
      .long_pls (lng[i])
    );
  end

  assign bus.btn_level = level;
  assign bus.press_pls = press;
  assign bus.rel_pls   = rel;
  assign bus.long_pls  = lng;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench: active-high bank plus an active-low bank, D=4, L=20.
module tb_btn_debounce_multi;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  btn_debounce_multi_if #(.NUM_CH(4)) bus ();
  btn_debounce_multi_if #(.NUM_CH(4)) bus_n ();

  btn_debounce_multi #(
    .NUM_CH(4), .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20), .ACTIVE_LOW(0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  btn_debounce_multi #(
    .NUM_CH(4), .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20), .ACTIVE_LOW(1)
  ) dut_n (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_n.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.btn_raw = 4'h0;
    bus_n.btn_raw = 4'hF;
    repeat (3) tick();
    tests++;
    if ({bus.btn_level, bus.press_pls, bus.rel_pls, bus.long_pls} !== 16'h0) begin
      fails++;
      $display("FAIL reset_hi outputs got %h want 0000",
        {bus.btn_level, bus.press_pls, bus.rel_pls, bus.long_pls});
    end
    tests++;
    if ({bus_n.btn_level, bus_n.press_pls, bus_n.rel_pls, bus_n.long_pls} !== 16'h0) begin
      fails++;
      $display("FAIL reset_lo outputs got %h want 0000",
        {bus_n.btn_level, bus_n.press_pls, bus_n.rel_pls, bus_n.long_pls});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clean_press();
    logic [3:0] el, ep;
    bus.btn_raw[0] = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      el = (t >= 6) ? 4'b0001 : 4'b0000;
      ep = (t == 6) ? 4'b0001 : 4'b0000;
      tests++;
      if (bus.btn_level !== el) begin
        fails++;
        $display("FAIL clean_level t=%0d got %b want %b", t, bus.btn_level, el);
      end
      tests++;
      if (bus.press_pls !== ep || bus.rel_pls !== 4'b0) begin
        fails++;
        $display("FAIL clean_pulse t=%0d press %b rel %b want press %b rel 0000",
          t, bus.press_pls, bus.rel_pls, ep);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] ep;
    for (int k = 0; k < 4; k++) begin
      bus.btn_raw[1] = (k % 2 == 0);
      repeat (3) begin
        tick();
        tests++;
        if (bus.press_pls !== 4'b0 || bus.rel_pls !== 4'b0 || bus.btn_level[1] !== 1'b0) begin
          fails++;
          $display("FAIL bounce_quiet k=%0d press %b rel %b lvl1 %b want 0",
            k, bus.press_pls, bus.rel_pls, bus.btn_level[1]);
        end
      end
    end
    bus.btn_raw[1] = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      ep = (t == 6) ? 4'b0010 : 4'b0000;
      tests++;
      if (bus.press_pls !== ep || bus.btn_level[1] !== (t >= 6)) begin
        fails++;
        $display("FAIL bounce_press t=%0d press %b lvl1 %b want press %b lvl1 %0d",
          t, bus.press_pls, bus.btn_level[1], ep, (t >= 6));
      end
    end
  endtask

  task automatic test_glitch();
    bus.btn_raw[2] = 1'b1;
    for (int t = 1; t <= 13; t++) begin
      if (t == 4) bus.btn_raw[2] = 1'b0;
      tick();
      tests++;
      if (bus.btn_level[2] !== 1'b0 || bus.press_pls !== 4'b0 || bus.rel_pls !== 4'b0) begin
        fails++;
        $display("FAIL glitch t=%0d lvl2 %b press %b rel %b want 0",
          t, bus.btn_level[2], bus.press_pls, bus.rel_pls);
      end
    end
  endtask

  task automatic test_long_press();
    logic [3:0] ep, elg, er;
    bus.btn_raw[3] = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      ep  = (t == 6) ? 4'b1000 : 4'b0000;
      elg = (LONG_ON && t == 26) ? 4'b1000 : 4'b0000;
      tests++;
      if (bus.press_pls !== ep || bus.rel_pls !== 4'b0) begin
        fails++;
        $display("FAIL long_press t=%0d press %b rel %b want press %b",
          t, bus.press_pls, bus.rel_pls, ep);
      end
      tests++;
      if (bus.long_pls !== elg || bus.btn_level[3] !== (t >= 6)) begin
        fails++;
        $display("FAIL long_pulse t=%0d long %b lvl3 %b want long %b",
          t, bus.long_pls, bus.btn_level[3], elg);
      end
    end
    bus.btn_raw[3] = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      er = (t == 6) ? 4'b1000 : 4'b0000;
      tests++;
      if (bus.rel_pls !== er || bus.long_pls !== 4'b0 || bus.btn_level[3] !== (t < 6)) begin
        fails++;
        $display("FAIL long_release t=%0d rel %b long %b lvl3 %b want rel %b",
          t, bus.rel_pls, bus.long_pls, bus.btn_level[3], er);
      end
    end
  endtask

  task automatic test_simul_reset();
    logic [3:0] e;
    bus.btn_raw[1:0] = 2'b00;
    for (int t = 1; t <= 8; t++) begin
      tick();
      e = (t == 6) ? 4'b0011 : 4'b0000;
      tests++;
      if (bus.rel_pls !== e || bus.press_pls !== 4'b0) begin
        fails++;
        $display("FAIL simul_rel t=%0d rel %b press %b want rel %b",
          t, bus.rel_pls, bus.press_pls, e);
      end
    end
    bus.btn_raw[1:0] = 2'b11;
    for (int t = 1; t <= 8; t++) begin
      tick();
      e = (t == 6) ? 4'b0011 : 4'b0000;
      tests++;
      if (bus.press_pls !== e || bus.rel_pls !== 4'b0) begin
        fails++;
        $display("FAIL simul_press t=%0d press %b rel %b want press %b",
          t, bus.press_pls, bus.rel_pls, e);
      end
    end
    bus.btn_raw[2] = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.btn_level, bus.press_pls, bus.rel_pls, bus.long_pls} !== 16'h0) begin
      fails++;
      $display("FAIL async_reset outputs got %h want 0000",
        {bus.btn_level, bus.press_pls, bus.rel_pls, bus.long_pls});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      e = (t == 6) ? 4'b0111 : 4'b0000;
      tests++;
      if (bus.press_pls !== e || bus.rel_pls !== 4'b0) begin
        fails++;
        $display("FAIL post_reset t=%0d press %b rel %b want press %b",
          t, bus.press_pls, bus.rel_pls, e);
      end
      tests++;
      if (bus.btn_level !== ((t >= 6) ? 4'b0111 : 4'b0000)) begin
        fails++;
        $display("FAIL post_reset_lvl t=%0d got %b", t, bus.btn_level);
      end
    end
  endtask

  task automatic test_active_low();
    logic [3:0] e;
    bus_n.btn_raw[0] = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      e = (t == 6) ? 4'b0001 : 4'b0000;
      tests++;
      if (bus_n.press_pls !== e || bus_n.btn_level[0] !== (t >= 6)) begin
        fails++;
        $display("FAIL alow_press t=%0d press %b lvl0 %b want press %b",
          t, bus_n.press_pls, bus_n.btn_level[0], e);
      end
    end
    bus_n.btn_raw[0] = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      e = (t == 6) ? 4'b0001 : 4'b0000;
      tests++;
      if (bus_n.rel_pls !== e || bus_n.btn_level[0] !== (t < 6)) begin
        fails++;
        $display("FAIL alow_release t=%0d rel %b lvl0 %b want rel %b",
          t, bus_n.rel_pls, bus_n.btn_level[0], e);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_long_press();
    test_simul_reset();
    test_active_low();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
